// File: rtl/data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// data_mem_access_unit
//
// CPU-side load/store engine that drives the byte-addressed data RAM port.
// It takes one load/store request at a time from the pipeline. It checks the
// size, alignment and address range of each request, and drives the RAM
// control signals. Load data is sign- or zero-extended, and each request
// completes with a single-cycle response pulse.
//
// The RAM writes on negedge clk and registers DataOUT on posedge clk. Every
// output is registered except req_ready, which is high only in IDLE.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   req_valid/ready   request handshake (accepted when both high at posedge)
//   req_write         1 = store, 0 = load
//   req_size          0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_unsigned      loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr          byte address
//   req_wdata         store data (low bytes used according to size)
//   resp_valid        one-cycle completion pulse, no backpressure
//   resp_error        misaligned / out-of-range / illegal size
//   resp_rdata        extended load data (0 for stores and errors)
//   LoadSelect        to RAM: access size
//   Address           to RAM: byte address
//   DataIN            to RAM: write data
//   Write             to RAM: write strobe
//   DataOUT           from RAM: read data (bytes above the access size undefined)
// ---------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        LoadSelect,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       DataIN,
  output logic              Write,
  input  logic [31:0]       DataOUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_error_q, resp_error_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic [1:0]          load_select_q, load_select_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [31:0]         data_in_q, data_in_d;
  logic                write_q, write_d;
  logic                unsigned_q, unsigned_d;

  logic                req_error;
  logic                addr_out_of_range;
  logic                sign_ext;
  logic [31:0]         load_ext;

  // Any address bit at or above ADDR_W lies outside the RAM.
  assign addr_out_of_range = |req_addr[31:ADDR_W];

  // Request-time error check. A request that passes the alignment check
  // cannot run past the top of the RAM, so no wrap check is needed.
  always_comb begin
    req_error = 1'b0;
    if (req_size == 2'd3) begin
      req_error = 1'b1;
    end
    if (addr_out_of_range) begin
      req_error = 1'b1;
    end
    if (req_size == 2'd1 && req_addr[0]) begin
      req_error = 1'b1;
    end
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00) begin
      req_error = 1'b1;
    end
  end

  // Extension uses only the bytes that belong to the access. Undefined upper
  // DataOUT bytes therefore never reach resp_rdata.
  assign sign_ext = ~unsigned_q;

  always_comb begin
    load_ext = DataOUT;
    case (load_select_q)
      2'd0:    load_ext = {{24{sign_ext & DataOUT[7]}}, DataOUT[7:0]};
      2'd1:    load_ext = {{16{sign_ext & DataOUT[15]}}, DataOUT[15:0]};
      default: load_ext = DataOUT;
    endcase
  end

  // Next-state and output logic. resp_valid and resp_error default to 0, so
  // they are high only in the DONE cycle that a transition sets them for.
  always_comb begin
    state_d       = state_q;
    resp_valid_d  = 1'b0;
    resp_error_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    load_select_d = load_select_q;
    address_d     = address_q;
    data_in_d     = data_in_q;
    write_d       = write_q;
    unsigned_d    = unsigned_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_error) begin
            // Rejected requests never touch the RAM.
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d       = ACCESS;
            address_d     = req_addr[ADDR_W-1:0];
            load_select_d = req_size;
            data_in_d     = req_wdata;
            write_d       = req_write;
            unsigned_d    = req_unsigned;
          end
        end
      end

      ACCESS: begin
        // The write strobe lasts exactly this one cycle. The RAM writes at
        // the negedge and samples Address at the closing posedge.
        write_d = 1'b0;
        if (write_q) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
        end else begin
          state_d = READ;
        end
      end

      READ: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset is asynchronous, so Write drops and any pending
  // response is discarded as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      load_select_q <= 2'd0;
      address_q     <= '0;
      data_in_q     <= 32'h0;
      write_q       <= 1'b0;
      unsigned_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_rdata_q  <= resp_rdata_d;
      load_select_q <= load_select_d;
      address_q     <= address_d;
      data_in_q     <= data_in_d;
      write_q       <= write_d;
      unsigned_q    <= unsigned_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign LoadSelect = load_select_q;
  assign Address    = address_q;
  assign DataIN     = data_in_q;
  assign Write      = write_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_access_unit
//
// Directed testbench for data_mem_access_unit. It includes a behavioural
// data RAM: writes happen on negedge clk, and DataOUT is registered on
// posedge clk. Bytes above the access size are driven as X, so any leak of
// undefined data into resp_rdata shows up.
// ---------------------------------------------------------------------------
module tb_data_mem_access_unit;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_error;
  logic [31:0]       resp_rdata;
  logic [1:0]        LoadSelect;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIN;
  logic              Write;
  logic [31:0]       DataOUT;

  int testsRun    = 0;
  int testsFailed = 0;

  // Results captured by applyStimulus for the most recent request.
  int          lastEdges;
  int          lastWriteCycles;
  logic        lastGotResp;
  logic        lastError;
  logic [31:0] lastRdata;
  logic [1:0]  lastLoadSelect;
  logic [31:0] lastAddress;

  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic [31:0] ramRead;

  data_mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_error   (resp_error),
    .resp_rdata   (resp_rdata),
    .LoadSelect   (LoadSelect),
    .Address      (Address),
    .DataIN       (DataIN),
    .Write        (Write),
    .DataOUT      (DataOUT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM write port: little-endian, and only the bytes covered by LoadSelect.
  always @(negedge clk) begin
    if (Write) begin
      mem[Address] <= DataIN[7:0];
      if (LoadSelect != 2'd0) begin
        mem[Address + 10'd1] <= DataIN[15:8];
      end
      if (LoadSelect[1]) begin
        mem[Address + 10'd2] <= DataIN[23:16];
        mem[Address + 10'd3] <= DataIN[31:24];
      end
    end
  end

  // RAM read port: registered. Bytes outside the access size are X.
  always @(posedge clk) begin
    ramRead = 'x;
    ramRead[7:0] = mem[Address];
    if (LoadSelect != 2'd0) begin
      ramRead[15:8] = mem[Address + 10'd1];
    end
    if (LoadSelect[1]) begin
      ramRead[23:16] = mem[Address + 10'd2];
      ramRead[31:24] = mem[Address + 10'd3];
    end
    DataOUT <= ramRead;
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request, starting #1 after a posedge with the DUT in IDLE.
  // It then counts posedges, including the accept edge, up to resp_valid,
  // and counts how many cycles Write was high. After the response it checks
  // that the pulse lasts one cycle and that req_ready returns.
  task automatic applyStimulus(input string tag, input logic wr,
                               input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd);
    checkOutput({tag, "_ready_before"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    // Drive junk after acceptance; the DUT must ignore it outside IDLE.
    req_valid    = 1'b0;
    req_write    = ~wr;
    req_size     = 2'd3;
    req_unsigned = ~uns;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h5A5A_5A5A;
    lastEdges       = 1;
    lastWriteCycles = 0;
    lastGotResp     = 1'b0;
    while (!lastGotResp && lastEdges <= 8) begin
      if (Write) lastWriteCycles++;
      if (resp_valid) begin
        lastGotResp    = 1'b1;
        lastError      = resp_error;
        lastRdata      = resp_rdata;
        lastLoadSelect = LoadSelect;
        lastAddress    = {22'h0, Address};
      end else begin
        @(posedge clk);
        #1;
        lastEdges++;
      end
    end
    checkOutput({tag, "_got_resp"}, {31'h0, lastGotResp}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drops"}, {31'h0, resp_valid}, 32'h0);
    checkOutput({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    #1;
    checkOutput("rst_ready",      {31'h0, req_ready},  32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_error", {31'h0, resp_error}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata,          32'h0);
    checkOutput("rst_loadselect", {30'h0, LoadSelect}, 32'h0);
    checkOutput("rst_address",    {22'h0, Address},    32'h0);
    checkOutput("rst_datain",     DataIN,              32'h0);
    checkOutput("rst_write",      {31'h0, Write},      32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store then word load at 0x28.
    applyStimulus("st_w28", 1'b1, 2'd2, 1'b0, 32'h28, 32'hDEAD_BEEF);
    checkOutput("st_w28_edges",  lastEdges,           32'd2);
    checkOutput("st_w28_wrcyc",  lastWriteCycles,     32'd1);
    checkOutput("st_w28_err",    {31'h0, lastError},  32'h0);
    checkOutput("st_w28_rdata",  lastRdata,           32'h0);
    checkOutput("st_w28_lsel",   {30'h0, lastLoadSelect}, 32'h2);
    checkOutput("st_w28_addr",   lastAddress,         32'h28);
    applyStimulus("ld_w28", 1'b0, 2'd2, 1'b0, 32'h28, 32'h0);
    checkOutput("ld_w28_edges",  lastEdges,           32'd3);
    checkOutput("ld_w28_wrcyc",  lastWriteCycles,     32'd0);
    checkOutput("ld_w28_err",    {31'h0, lastError},  32'h0);
    checkOutput("ld_w28_rdata",  lastRdata,           32'hDEAD_BEEF);

    // Byte store 0x80 at 0x29. Only the low byte of wdata may be written.
    applyStimulus("st_b29", 1'b1, 2'd0, 1'b0, 32'h29, 32'h1234_5680);
    checkOutput("st_b29_edges",  lastEdges,           32'd2);
    checkOutput("st_b29_wrcyc",  lastWriteCycles,     32'd1);
    applyStimulus("ld_b29s", 1'b0, 2'd0, 1'b0, 32'h29, 32'h0);
    checkOutput("ld_b29s_rdata", lastRdata,           32'hFFFF_FF80);
    applyStimulus("ld_b29u", 1'b0, 2'd0, 1'b1, 32'h29, 32'h0);
    checkOutput("ld_b29u_rdata", lastRdata,           32'h0000_0080);
    applyStimulus("ld_w28b", 1'b0, 2'd2, 1'b0, 32'h28, 32'h0);
    checkOutput("ld_w28b_rdata", lastRdata,           32'hDEAD_80EF);

    // Halfword loads at 0x2A. The RAM drives X in the upper bytes.
    applyStimulus("ld_h2As", 1'b0, 2'd1, 1'b0, 32'h2A, 32'h0);
    checkOutput("ld_h2As_rdata", lastRdata,           32'hFFFF_DEAD);
    checkOutput("ld_h2As_err",   {31'h0, lastError},  32'h0);
    applyStimulus("ld_h2Au", 1'b0, 2'd1, 1'b1, 32'h2A, 32'h0);
    checkOutput("ld_h2Au_rdata", lastRdata,           32'h0000_DEAD);

    // Error cases: one-edge response, error flag, no RAM write.
    applyStimulus("err_h101", 1'b1, 2'd1, 1'b0, 32'h101, 32'h1111_1111);
    checkOutput("err_h101_edges", lastEdges,          32'd1);
    checkOutput("err_h101_err",   {31'h0, lastError}, 32'h1);
    checkOutput("err_h101_wrcyc", lastWriteCycles,    32'd0);
    checkOutput("err_h101_rdata", lastRdata,          32'h0);
    applyStimulus("err_w102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    checkOutput("err_w102_edges", lastEdges,          32'd1);
    checkOutput("err_w102_err",   {31'h0, lastError}, 32'h1);
    checkOutput("err_w102_rdata", lastRdata,          32'h0);
    applyStimulus("err_sz3", 1'b1, 2'd3, 1'b0, 32'h0, 32'h2222_2222);
    checkOutput("err_sz3_edges",  lastEdges,          32'd1);
    checkOutput("err_sz3_err",    {31'h0, lastError}, 32'h1);
    checkOutput("err_sz3_wrcyc",  lastWriteCycles,    32'd0);
    applyStimulus("err_a400", 1'b1, 2'd2, 1'b0, 32'h400, 32'h3333_3333);
    checkOutput("err_a400_edges", lastEdges,          32'd1);
    checkOutput("err_a400_err",   {31'h0, lastError}, 32'h1);
    checkOutput("err_a400_wrcyc", lastWriteCycles,    32'd0);
    // The rejected size-3 store at address 0 must not have changed memory.
    applyStimulus("ld_w00", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checkOutput("ld_w00_rdata",   lastRdata,          32'h0);

    // Top-of-memory word access.
    applyStimulus("st_w3FC", 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFE_F00D);
    checkOutput("st_w3FC_err",   {31'h0, lastError},  32'h0);
    checkOutput("st_w3FC_edges", lastEdges,           32'd2);
    applyStimulus("ld_w3FC", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    checkOutput("ld_w3FC_err",   {31'h0, lastError},  32'h0);
    checkOutput("ld_w3FC_rdata", lastRdata,           32'hCAFE_F00D);

    // Reset raised in the middle of a store's ACCESS cycle.
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h40;
    req_wdata    = 32'h7777_7777;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rstmid_write_hi", {31'h0, Write}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_write_lo", {31'h0, Write},      32'h0);
    checkOutput("rstmid_ready",    {31'h0, req_ready},  32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int sawValid;
      sawValid = 0;
      for (int c = 0; c < 4; c++) begin
        if (resp_valid) sawValid++;
        @(posedge clk);
        #1;
      end
      checkOutput("rstmid_no_resp", sawValid, 32'd0);
    end
    checkOutput("rstmid_ready_after", {31'h0, req_ready}, 32'h1);
    // The interrupted store must not have reached memory.
    applyStimulus("ld_w40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    checkOutput("ld_w40_rdata", lastRdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
